// File: rtl/vga_sync_decoder_if.sv
// Sync/blank inputs and recovered timing outputs for vga_sync_decoder.
// master: the video source / observer side. slave: the decoder.
interface vga_sync_decoder_if;
  logic       hsync_in;
  logic       vsync_in;
  logic       blank_in;
  logic [9:0] hcount_out;
  logic [9:0] vcount_out;
  logic       blank_out;
  logic       locked_out;
  logic       frame_start_out;
  logic       err_out;
  logic [7:0] err_count_out;

  modport master (
    output hsync_in, vsync_in, blank_in,
    input  hcount_out, vcount_out, blank_out, locked_out,
           frame_start_out, err_out, err_count_out
  );

  modport slave (
    input  hsync_in, vsync_in, blank_in,
    output hcount_out, vcount_out, blank_out, locked_out,
           frame_start_out, err_out, err_count_out
  );
endinterface

// File: rtl/vga_sync_decoder.sv
// VGA sync decoder: recovers pixel/line counters from hsync/vsync, acquires
// lock (SEARCH -> HACQ -> VACQ -> LOCKED) and flags timing violations.
// Optional feature macro: VGA_RX_BLANK_CHECK_EN -- when defined, a blank_in
// that disagrees with the recovered blank while locked counts as a violation.
module vga_sync_decoder #(
  parameter int H_SIZE       = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC_PULSE = 96,
  parameter int H_BP         = 48,
  parameter int V_SIZE       = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC_PULSE = 2,
  parameter int V_BP         = 33,
  parameter int LOCK_LINES   = 4
) (
  input logic                clk_in,
  input logic                rst_n_in,
  vga_sync_decoder_if.slave  bus
);
  localparam int H_TOTAL = H_SIZE + H_FP + H_SYNC_PULSE + H_BP;
  localparam int V_TOTAL = V_SIZE + V_FP + V_SYNC_PULSE + V_BP;
  localparam int GW      = (LOCK_LINES > 1) ? $clog2(LOCK_LINES) : 1;

  localparam logic [9:0]    H_EXP     = 10'(H_SIZE + H_FP);
  localparam logic [9:0]    H_LOAD    = 10'(H_SIZE + H_FP + 1);
  localparam logic [9:0]    H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]    H_PER     = 10'(H_TOTAL);
  localparam logic [9:0]    H_ACT     = 10'(H_SIZE);
  localparam logic [9:0]    V_EXP     = 10'(V_SIZE + V_FP);
  localparam logic [9:0]    V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]    V_ACT     = 10'(V_SIZE);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_LINES - 1);

  typedef enum logic [1:0] {SEARCH, HACQ, VACQ, LOCKED} state_t;

  state_t        state;
  logic          hs_q, vs_q;
  logic [9:0]    per_cnt;
  logic [GW-1:0] good_cnt;

  logic       hs_fall, vs_fall, h_wrap;
  logic [9:0] h_nxt, v_nxt;
  logic       line_bad, line_good, viol, act_nxt, org_nxt, blank_bad;

  // Edge detect against the registered level: a fall is seen in the same
  // cycle the low level first appears on the input.
  assign hs_fall = hs_q & ~bus.hsync_in;
  assign vs_fall = vs_q & ~bus.vsync_in;

  // An hsync fall realigns so the count matches the source from the next
  // cycle; a load suppresses the wrap so vcount is not bumped twice.
  assign h_wrap = !hs_fall && (bus.hcount_out == H_LAST);
  assign h_nxt  = hs_fall ? H_LOAD : (h_wrap ? 10'd0 : bus.hcount_out + 10'd1);
  assign v_nxt  = vs_fall ? V_EXP :
                  (h_wrap ? ((bus.vcount_out == V_LAST) ? 10'd0 : bus.vcount_out + 10'd1)
                          : bus.vcount_out);

  assign act_nxt = (h_nxt < H_ACT) && (v_nxt < V_ACT);
  assign org_nxt = (h_nxt == 10'd0) && (v_nxt == 10'd0);

  // Line quality during acquisition: exact period on a fall, or overdue.
  assign line_good = hs_fall && (per_cnt == H_PER);
  assign line_bad  = (hs_fall && (per_cnt != H_PER)) || (per_cnt > H_PER);

`ifdef VGA_RX_BLANK_CHECK_EN
  assign blank_bad = bus.blank_in != bus.blank_out;
`else
  assign blank_bad = 1'b0;
`endif

  // Locked-state expectations: hsync falls only at H_SIZE+H_FP (and must
  // arrive there), vsync falls only at (0, V_SIZE+V_FP).
  assign viol = (hs_fall && (bus.hcount_out != H_EXP)) ||
                (!hs_fall && (bus.hcount_out == H_EXP)) ||
                (vs_fall && ((bus.hcount_out != 10'd0) || (bus.vcount_out != V_EXP))) ||
                blank_bad;

  // Free-running counters, sync input registers and line-period counter.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hs_q           <= 1'b1;
      vs_q           <= 1'b1;
      bus.hcount_out <= '0;
      bus.vcount_out <= '0;
      per_cnt        <= '0;
    end else begin
      hs_q           <= bus.hsync_in;
      vs_q           <= bus.vsync_in;
      bus.hcount_out <= h_nxt;
      bus.vcount_out <= v_nxt;
      if (hs_fall)               per_cnt <= 10'd1;
      else if (per_cnt != 10'h3FF) per_cnt <= per_cnt + 10'd1;
    end
  end

  // Acquisition FSM with registered lock, blank, frame-start and error outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state               <= SEARCH;
      good_cnt            <= '0;
      bus.locked_out      <= 1'b0;
      bus.blank_out       <= 1'b1;
      bus.frame_start_out <= 1'b0;
      bus.err_out         <= 1'b0;
      bus.err_count_out   <= '0;
    end else begin
      bus.locked_out      <= 1'b0;
      bus.blank_out       <= 1'b1;
      bus.frame_start_out <= 1'b0;
      bus.err_out         <= 1'b0;
      case (state)
        SEARCH: if (hs_fall) begin
          state    <= HACQ;
          good_cnt <= '0;
        end
        HACQ: begin
          if (line_bad) state <= SEARCH;
          else if (line_good) begin
            if (good_cnt == GOOD_LAST) state <= VACQ;
            else good_cnt <= good_cnt + 1'b1;
          end
        end
        VACQ: begin
          if (line_bad) state <= SEARCH;
          else if (vs_fall) begin
            state               <= LOCKED;
            bus.locked_out      <= 1'b1;
            bus.blank_out       <= !act_nxt;
            bus.frame_start_out <= org_nxt;
          end
        end
        LOCKED: begin
          if (viol) begin
            state       <= SEARCH;
            bus.err_out <= 1'b1;
            if (bus.err_count_out != 8'hFF) bus.err_count_out <= bus.err_count_out + 8'd1;
          end else begin
            bus.locked_out      <= 1'b1;
            bus.blank_out       <= !act_nxt;
            bus.frame_start_out <= org_nxt;
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end
endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder: a small-timing VGA generator drives the decoder;
// recovered position, blank, frame start, lock and error outputs are compared
// against the generator's own raster position and an injected-error tally.
module tb_vga_sync_decoder;
  localparam int HS = 8, HF = 2, HP = 4, HB = 2;
  localparam int VS = 6, VF = 1, VP = 2, VB = 1;
  localparam int LL = 4;
  localparam int HT = HS + HF + HP + HB;
  localparam int VT = VS + VF + VP + VB;

  logic clk_in   = 1'b0;
  logic rst_n_in = 1'b0;

  vga_sync_decoder_if bus();

  vga_sync_decoder #(
    .H_SIZE(HS), .H_FP(HF), .H_SYNC_PULSE(HP), .H_BP(HB),
    .V_SIZE(VS), .V_FP(VF), .V_SYNC_PULSE(VP), .V_BP(VB),
    .LOCK_LINES(LL)
  ) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .bus      (bus)
  );

  always #5 clk_in = ~clk_in;

  int n_chk  = 0;
  int n_fail = 0;
  int gh = 0, gv = 0;
  int exp_errs = 0;
  bit hs_hi = 0, hs_lo = 0, bl_lo = 0, sync_off = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive the generator's sync/blank for the current raster position, clock,
  // then step the position; outputs are sampled 1 time unit after the edge.
  task automatic cycle();
    bus.hsync_in = sync_off || hs_hi || (!hs_lo && !(gh >= HS + HF && gh < HS + HF + HP));
    bus.vsync_in = sync_off || !(gv >= VS + VF && gv < VS + VF + VP);
    bus.blank_in = !bl_lo && (gh >= HS || gv >= VS);
    @(posedge clk_in);
    #1;
    gh++;
    if (gh == HT) begin
      gh = 0;
      gv = (gv + 1) % VT;
    end
  endtask

  task automatic trk();
    check("hcount",      32'(bus.hcount_out),      gh);
    check("vcount",      32'(bus.vcount_out),      gv);
    check("blank",       32'(bus.blank_out),       32'(gh >= HS || gv >= VS));
    check("frame_start", 32'(bus.frame_start_out), 32'(gh == 0 && gv == 0));
    check("locked",      32'(bus.locked_out),      1);
    check("err_idle",    32'(bus.err_out),         0);
  endtask

  task automatic run_to(input int h, input int v);
    while (!(gh == h && (v < 0 || gv == v))) begin
      cycle();
      trk();
    end
  endtask

  // Lock can only be declared the cycle after the vsync fall at (0, VS+VF).
  task automatic wait_lock(input string tag);
    int k = 0;
    while (bus.locked_out !== 1'b1 && k < 3 * VT * HT) begin
      cycle();
      k++;
      check({tag, "_no_err"}, 32'(bus.err_out), 0);
    end
    check({tag, "_locked"}, 32'(bus.locked_out), 1);
    check({tag, "_lock_h"}, gh, 1);
    check({tag, "_lock_v"}, gv, VS + VF);
  endtask

  task automatic chk_errcnt(input string tag);
    check(tag, 32'(bus.err_count_out), (exp_errs > 255) ? 255 : exp_errs);
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_hcount"}, 32'(bus.hcount_out),      0);
    check({tag, "_vcount"}, 32'(bus.vcount_out),      0);
    check({tag, "_blank"},  32'(bus.blank_out),       1);
    check({tag, "_locked"}, 32'(bus.locked_out),      0);
    check({tag, "_frame"},  32'(bus.frame_start_out), 0);
    check({tag, "_err"},    32'(bus.err_out),         0);
    check({tag, "_errcnt"}, 32'(bus.err_count_out),   0);
  endtask

  initial begin
    // Reset state with a random raster starting point.
    gh = $urandom_range(0, HT - 1);
    gv = $urandom_range(0, VT - 1);
    repeat (3) cycle();
    chk_reset("reset");
    rst_n_in = 1'b1;

    // No lock is possible before LL good lines have been seen.
    for (int i = 0; i < LL * HT; i++) begin
      cycle();
      check("early_unlocked", 32'(bus.locked_out), 0);
    end
    wait_lock("acq");

    // Three frames of exact tracking with no errors.
    for (int i = 0; i < 3 * VT * HT; i++) begin
      cycle();
      trk();
    end
    chk_errcnt("errcnt_clean");

    // Spurious hsync fall in the middle of the sync pulse on line 0.
    run_to(HS + HF + 1, 0);
    hs_hi = 1; cycle(); hs_hi = 0;
    trk();
    cycle();
    exp_errs++;
    check("glitch_err",    32'(bus.err_out),    1);
    check("glitch_locked", 32'(bus.locked_out), 0);
    chk_errcnt("glitch_errcnt");
    wait_lock("glitch_relock");

    // Sync inputs held high for two frames.
    run_to(0, 1);
    sync_off = 1;
    exp_errs++;
    for (int i = 0; i < 2 * VT * HT; i++) begin
      cycle();
      check("idle_frame", 32'(bus.frame_start_out), 0);
      if (i >= HT) begin
        check("idle_locked", 32'(bus.locked_out), 0);
        check("idle_blank",  32'(bus.blank_out),  1);
      end
    end
    chk_errcnt("idle_errcnt");
    sync_off = 0;
    wait_lock("idle_relock");

    // Asynchronous reset in the middle of an active line.
    run_to(5, 3);
    #2 rst_n_in = 1'b0;
    #1 chk_reset("midrst");
    repeat (3) cycle();
    rst_n_in = 1'b1;
    exp_errs = 0;
    wait_lock("rst_relock");

    // blank_in pulled low inside the horizontal front porch.
    run_to(HS + 1, -1);
    bl_lo = 1; cycle(); bl_lo = 0;
`ifdef VGA_RX_BLANK_CHECK_EN
    exp_errs++;
    check("blank_err",    32'(bus.err_out),    1);
    check("blank_locked", 32'(bus.locked_out), 0);
    chk_errcnt("blank_errcnt");
    wait_lock("blank_relock");
`else
    check("blank_ignored_err",    32'(bus.err_out),    0);
    check("blank_ignored_locked", 32'(bus.locked_out), 1);
    chk_errcnt("blank_ignored_errcnt");
`endif

    // Repeated violations drive the error counter into saturation; after each
    // one the raster jumps near the vsync line to shorten reacquisition.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        run_to(HS + HF + 1, -1);
        hs_hi = 1; cycle(); hs_hi = 0;
        cycle();
      end else begin
        run_to($urandom_range(2, HS), -1);
        hs_lo = 1; cycle(); hs_lo = 0;
      end
      exp_errs++;
      check("sat_err",    32'(bus.err_out),    1);
      check("sat_locked", 32'(bus.locked_out), 0);
      chk_errcnt("sat_errcnt");
      gv = VS + VF - 6;
      wait_lock("sat_relock");
    end
    check("sat_final", 32'(bus.err_count_out), 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
